// File: rtl/lif_neuron_layer.sv
// Leaky integrate-and-fire layer: accumulates packed signed currents into N membrane
// potentials, then on each timestep boundary applies leak, threshold/fire and refractory.
module lif_neuron_layer #(
    parameter int N_NEURON   = 3,
    parameter int W_WIDTH    = 16,
    parameter int THRESH     = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cur_valid,
    input  logic [N_NEURON*W_WIDTH-1:0] cur_in,
    output logic                        in_ready,
    input  logic                        step_end,
    output logic [N_NEURON-1:0]         spike_out,
    output logic                        spike_valid,
    output logic [N_NEURON*W_WIDTH-1:0] v_mem,
    output logic                        step_overrun
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RW-1:0]             REFRAC_V = RW'(REFRAC);
    localparam logic signed [W_WIDTH-1:0] THRESH_V = W_WIDTH'(THRESH);

    typedef enum logic [1:0] {ACCUM, LEAK, FIRE} state_t;

    state_t state, state_next;

    logic signed [W_WIDTH-1:0] v      [N_NEURON];
    logic signed [W_WIDTH-1:0] cur_w  [N_NEURON];
    logic        [RW-1:0]      refrac [N_NEURON];

    // Neuron 0 occupies the most significant word of both packed buses.
    for (genvar k = 0; k < N_NEURON; k++) begin : g_pack
        assign cur_w[k] = cur_in[W_WIDTH*(N_NEURON-1-k) +: W_WIDTH];
        assign v_mem[W_WIDTH*(N_NEURON-1-k) +: W_WIDTH] = v[k];
    end

    function automatic logic signed [W_WIDTH-1:0] sat_add(
        input logic signed [W_WIDTH-1:0] a,
        input logic signed [W_WIDTH-1:0] b
    );
        logic signed [W_WIDTH:0] s;
        s = {a[W_WIDTH-1], a} + {b[W_WIDTH-1], b};
        // Extra sign bit disagreeing with the top result bit means the sum left the range.
        if (s[W_WIDTH] != s[W_WIDTH-1])
            return s[W_WIDTH] ? {1'b1, {(W_WIDTH-1){1'b0}}} : {1'b0, {(W_WIDTH-1){1'b1}}};
        return s[W_WIDTH-1:0];
    endfunction

    function automatic logic signed [W_WIDTH-1:0] leak(input logic signed [W_WIDTH-1:0] x);
        if (LEAK_SHIFT == 0)
            return x;
        return x - (x >>> LEAK_SHIFT);
    endfunction

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACCUM;
        else
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples pre-edge values regardless of process ordering.
            state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ACCUM:   if (step_end) state_next = LEAK;
            LEAK:    state_next = FIRE;
            FIRE:    state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-neuron arrays are a handful of flops, not a RAM, so they
            // take the async reset like any other state.
            for (int k = 0; k < N_NEURON; k++) begin
                v[k]      <= '0;
                refrac[k] <= '0;
            end
            spike_out    <= '0;
            spike_valid  <= 1'b0;
            step_overrun <= 1'b0;
        end else begin
            spike_valid <= 1'b0;
            if (step_end && !in_ready)
                step_overrun <= 1'b1;
            case (state)
                ACCUM: begin
                    for (int k = 0; k < N_NEURON; k++)
                        if (cur_valid && refrac[k] == '0)
                            v[k] <= sat_add(v[k], cur_w[k]);
                end
                LEAK: begin
                    for (int k = 0; k < N_NEURON; k++)
                        v[k] <= leak(v[k]);
                end
                FIRE: begin
                    spike_valid <= 1'b1;
                    for (int k = 0; k < N_NEURON; k++) begin
                        if (refrac[k] == '0 && v[k] >= THRESH_V) begin
                            spike_out[N_NEURON-1-k] <= 1'b1;
                            v[k]                    <= '0;
                            refrac[k]               <= REFRAC_V;
                        end else begin
                            spike_out[N_NEURON-1-k] <= 1'b0;
                            if (refrac[k] != '0)
                                refrac[k] <= refrac[k] - RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
